// File: rtl/reg_bank_pipe.sv
// reg_bank_pipe
//   General-purpose register bank with a dedicated program-counter register,
//   one write port, one PC load port and two registered read ports.
//
//   Parameters
//     DATA_W  width of every register and data port
//     ADDR_W  address width; the bank holds 2**ADDR_W registers
//     PC_IDX  index of the program-counter register
//
//   Ports
//     clk            rising-edge clock
//     rst            synchronous active-high reset
//     we, wa, wd     general write port (writes to PC_IDX are ignored)
//     pc_we, pc_in   program-counter load port
//     re1, ra1       read port 1 request / address
//     re2, ra2       read port 2 request / address
//     rd1, rd2       registered read data, held when not requested
//     rv1, rv2       one-cycle read-valid strobes
//     pc_out         current program-counter register contents
//
//   Build option
//     REG_BANK_BYPASS_EN  defined: a read returns data written at the same edge.
//                         undefined: a read returns the value before the edge.
module reg_bank_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int PC_IDX = (2 ** ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              pc_we,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              re1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rv1,
  output logic              rv2,
  output logic [DATA_W-1:0] pc_out
);

  localparam int unsigned NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic              rv1_q, rv1_d, rv2_q, rv2_d;

  always_comb begin
    regs_d = regs_q;
    // The PC register is owned by the PC port; general writes to it are dropped.
    if (we && (wa != PC_A)) regs_d[wa] = wd;
    if (pc_we)              regs_d[PC_IDX] = pc_in;

    rd1_d = rd1_q;
    rv1_d = 1'b0;
    rd2_d = rd2_q;
    rv2_d = 1'b0;
`ifdef REG_BANK_BYPASS_EN
    // Reading the next-state array forwards same-edge writes, including pc_in.
    if (re1) begin
      rd1_d = regs_d[ra1];
      rv1_d = 1'b1;
    end
    if (re2) begin
      rd2_d = regs_d[ra2];
      rv2_d = 1'b1;
    end
`else
    if (re1) begin
      rd1_d = regs_q[ra1];
      rv1_d = 1'b1;
    end
    if (re2) begin
      rd2_d = regs_q[ra2];
      rv2_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      rd1_q <= '0;
      rd2_q <= '0;
      rv1_q <= 1'b0;
      rv2_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      rv1_q  <= rv1_d;
      rv2_q  <= rv2_d;
    end
  end

  assign rd1    = rd1_q;
  assign rd2    = rd2_q;
  assign rv1    = rv1_q;
  assign rv2    = rv2_q;
  assign pc_out = regs_q[PC_IDX];

endmodule

// File: tb/tb_reg_bank_pipe.sv
// Directed, table-driven bench for reg_bank_pipe (DATA_W=32, ADDR_W=4, PC_IDX=15).
// Expected same-edge read-after-write data depends on REG_BANK_BYPASS_EN.
module tb_reg_bank_pipe;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, we, pc_we, re1, re2;
  logic [3:0]  wa, ra1, ra2;
  logic [31:0] wd, pc_in;
  logic [31:0] rd1, rd2, pc_out;
  logic        rv1, rv2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_bank_pipe #(.DATA_W(32), .ADDR_W(4), .PC_IDX(15)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .pc_we(pc_we), .pc_in(pc_in),
    .re1(re1), .re2(re2), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2), .rv1(rv1), .rv2(rv2), .pc_out(pc_out)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        pc_we;
    logic [31:0] pc_in;
    logic        re1;
    logic [3:0]  ra1;
    logic        re2;
    logic [3:0]  ra2;
    logic [31:0] e_rd1;
    logic        e_rv1;
    logic [31:0] e_rd2;
    logic        e_rv2;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic pw, input logic [31:0] pd,
                       input logic e1, input logic [3:0] a1, input logic e2, input logic [3:0] a2);
    @(negedge clk);
    rst = r; we = w; wa = a; wd = d; pc_we = pw; pc_in = pd;
    re1 = e1; ra1 = a1; re2 = e2; ra2 = a2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ba, bp;
    ba = BYP ? 32'hB : 32'hA;
    bp = BYP ? 32'h200 : 32'h0;

    //          rst we wa  wd            pwe pc_in     re1 ra1 re2 ra2  rd1          rv1 rd2           rv2 pc
    vecs[0]  = '{1, 0, 0,  32'h0,        0, 32'h0,    1, 3,  0, 0,  32'h0,       0, 32'h0,        0, 32'h0};
    vecs[1]  = '{0, 0, 0,  32'h0,        0, 32'h0,    1, 3,  0, 0,  32'h0,       1, 32'h0,        0, 32'h0};
    vecs[2]  = '{0, 1, 5,  32'hDEADBEEF, 0, 32'h0,    0, 0,  0, 0,  32'h0,       0, 32'h0,        0, 32'h0};
    vecs[3]  = '{0, 0, 0,  32'h0,        0, 32'h0,    0, 0,  1, 5,  32'h0,       0, 32'hDEADBEEF, 1, 32'h0};
    vecs[4]  = '{0, 1, 15, 32'h1234,     0, 32'h0,    0, 0,  0, 0,  32'h0,       0, 32'hDEADBEEF, 0, 32'h0};
    vecs[5]  = '{0, 0, 0,  32'h0,        0, 32'h0,    1, 15, 0, 0,  32'h0,       1, 32'hDEADBEEF, 0, 32'h0};
    vecs[6]  = '{0, 0, 0,  32'h0,        1, 32'h100,  0, 0,  0, 0,  32'h0,       0, 32'hDEADBEEF, 0, 32'h100};
    vecs[7]  = '{0, 0, 0,  32'h0,        0, 32'h0,    1, 15, 0, 0,  32'h100,     1, 32'hDEADBEEF, 0, 32'h100};
    vecs[8]  = '{0, 1, 7,  32'hA,        0, 32'h0,    0, 0,  0, 0,  32'h100,     0, 32'hDEADBEEF, 0, 32'h100};
    vecs[9]  = '{0, 1, 7,  32'hB,        0, 32'h0,    1, 7,  0, 0,  ba,          1, 32'hDEADBEEF, 0, 32'h100};
    vecs[10] = '{0, 0, 0,  32'h0,        0, 32'h0,    0, 0,  1, 7,  ba,          0, 32'hB,        1, 32'h100};
    vecs[11] = '{0, 1, 2,  32'h55,       0, 32'h0,    0, 0,  0, 0,  ba,          0, 32'hB,        0, 32'h100};
    vecs[12] = '{1, 0, 0,  32'h0,        0, 32'h0,    1, 2,  0, 0,  32'h0,       0, 32'h0,        0, 32'h0};
    vecs[13] = '{0, 1, 9,  32'h77,       0, 32'h0,    1, 2,  0, 0,  32'h0,       1, 32'h0,        0, 32'h0};
    vecs[14] = '{0, 0, 0,  32'h0,        0, 32'h0,    1, 9,  1, 9,  32'h77,      1, 32'h77,       1, 32'h0};
    vecs[15] = '{0, 0, 0,  32'h0,        0, 32'h0,    0, 0,  0, 0,  32'h77,      0, 32'h77,       0, 32'h0};
    vecs[16] = '{0, 0, 0,  32'h0,        1, 32'h200,  1, 15, 1, 9,  bp,          1, 32'h77,       1, 32'h200};
    vecs[17] = '{1, 1, 4,  32'h99,       1, 32'h5,    1, 4,  0, 0,  32'h0,       0, 32'h0,        0, 32'h0};
    vecs[18] = '{0, 0, 0,  32'h0,        0, 32'h0,    1, 4,  0, 0,  32'h0,       1, 32'h0,        0, 32'h0};
    vecs[19] = '{0, 1, 15, 32'h1234,     1, 32'h300,  0, 0,  0, 0,  32'h0,       0, 32'h0,        0, 32'h300};
    vecs[20] = '{0, 0, 0,  32'h0,        0, 32'h0,    1, 15, 0, 0,  32'h300,     1, 32'h0,        0, 32'h300};

    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; pc_we = 1'b0; pc_in = '0;
    re1 = 1'b0; ra1 = '0; re2 = 1'b0; ra2 = '0;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].pc_we, vecs[i].pc_in,
            vecs[i].re1, vecs[i].ra1, vecs[i].re2, vecs[i].ra2);
      check($sformatf("v%0d rd1", i), rd1, vecs[i].e_rd1);
      check($sformatf("v%0d rv1", i), {31'b0, rv1}, {31'b0, vecs[i].e_rv1});
      check($sformatf("v%0d rd2", i), rd2, vecs[i].e_rd2);
      check($sformatf("v%0d rv2", i), {31'b0, rv2}, {31'b0, vecs[i].e_rv2});
      check($sformatf("v%0d pc_out", i), pc_out, vecs[i].e_pc);
    end

    // Fill every general register, then read back with the ports crossing addresses.
    for (int i = 0; i < 15; i++)
      drive(1'b0, 1'b1, 4'(i), 32'h1000 + 32'(i), 1'b0, '0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 4'(i), 1'b1, 4'(14 - i));
      check($sformatf("fill rd1 r%0d", i), rd1, 32'h1000 + 32'(i));
      check($sformatf("fill rd2 r%0d", 14 - i), rd2, 32'h1000 + 32'(14 - i));
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    check("fill rv1 idle", {31'b0, rv1}, 32'h0);
    check("fill pc kept", pc_out, 32'h300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
